// File: rtl/full_subtractor_pkg.sv
// Shared constants and the registered result record for the full_subtractor block.
// The ovf field is only driven when FULL_SUBTRACTOR_OVF_EN is defined.
package full_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int MAX_WIDTH     = 64;

    // diff is sized for the widest legal build; narrower builds use the low bits.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] diff;
        logic                 b_out;
        logic                 ovf;
    } result_t;

endpackage

// File: rtl/full_subtractor_fs_cell.sv
// One-bit combinational full-subtractor cell: the ripple element of full_subtractor.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic b_out
);

    assign diff  = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/full_subtractor.sv
// Registered WIDTH-bit ripple-borrow subtractor with 1-cycle latency and valid qualifier.
// Define FULL_SUBTRACTOR_OVF_EN to add the registered two's-complement overflow output ovf.
module full_subtractor
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
`ifdef FULL_SUBTRACTOR_OVF_EN
    output logic             ovf,
`endif
    output logic             b_out
);

    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff_c;

    result_t res_d, res_q;
    logic    valid_d, valid_q;

    assign borrow[0] = b_in;

    // Borrow ripples LSB to MSB through purely combinational cells.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fs_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .b_in  (borrow[i]),
            .diff  (diff_c[i]),
            .b_out (borrow[i+1])
        );
    end

    always_comb begin
        res_d   = res_q;
        valid_d = 1'b0;
        if (in_valid) begin
            res_d.diff             = '0;
            res_d.diff[WIDTH-1:0]  = diff_c;
            res_d.b_out            = borrow[WIDTH];
`ifdef FULL_SUBTRACTOR_OVF_EN
            res_d.ovf = (a[WIDTH-1] != b[WIDTH-1]) & (diff_c[WIDTH-1] != a[WIDTH-1]);
`endif
            valid_d = 1'b1;
        end
    end

    // Reset wins over a same-cycle operation, discarding it.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign diff      = res_q.diff[WIDTH-1:0];
    assign b_out     = res_q.b_out;
`ifdef FULL_SUBTRACTOR_OVF_EN
    assign ovf       = res_q.ovf;
`endif

    logic unused_res;
    assign unused_res = ^res_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Directed bench for full_subtractor: a WIDTH=1 and a WIDTH=8 instance share clock and reset.
module tb_full_subtractor;

    typedef struct {
        logic a;
        logic b;
        logic bin;
        logic diff;
        logic bout;
    } vec1_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec8_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       v1, a1, b1, bin1;
    logic       ov1, d1, bo1;
    logic       v8, bin8;
    logic [7:0] a8, b8;
    logic       ov8, bo8;
    logic [7:0] d8;
`ifdef FULL_SUBTRACTOR_OVF_EN
    logic       ovf1, ovf8;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .b_in      (bin1),
        .out_valid (ov1),
        .diff      (d1),
`ifdef FULL_SUBTRACTOR_OVF_EN
        .ovf       (ovf1),
`endif
        .b_out     (bo1)
    );

    full_subtractor #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .b_in      (bin8),
        .out_valid (ov8),
        .diff      (d8),
`ifdef FULL_SUBTRACTOR_OVF_EN
        .ovf       (ovf8),
`endif
        .b_out     (bo8)
    );

    task automatic applyStimulus(input logic iv1, input logic ia1, input logic ib1, input logic ibin1,
                                 input logic iv8, input logic [7:0] ia8, input logic [7:0] ib8,
                                 input logic ibin8);
        v1   = iv1;
        a1   = ia1;
        b1   = ib1;
        bin1 = ibin1;
        v8   = iv8;
        a8   = ia8;
        b8   = ib8;
        bin8 = ibin8;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec1_t      t1[8];
    vec8_t      t8[6];
    logic [8:0] model;
    logic [7:0] ra, rb;
    logic       rbin;

    initial begin
        t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        t1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        t1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        t1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        t1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        t1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        t1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        t1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        t8[0] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        t8[1] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        t8[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        t8[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        t8[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        t8[5] = '{8'h55, 8'h22, 1'b1, 8'h32, 1'b0, 1'b0};

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("reset_valid1", 16'(ov1), 16'h0);
        checkOutput("reset_diff8", 16'(d8), 16'h0);
        checkOutput("reset_bout8", 16'(bo8), 16'h0);
        checkOutput("reset_valid8", 16'(ov8), 16'h0);
        rst = 1'b0;

        // Truth table on WIDTH=1 and directed WIDTH=8 vectors, all back to back.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, t1[i].a, t1[i].b, t1[i].bin,
                          1'b1, t8[i % 6].a, t8[i % 6].b, t8[i % 6].bin);
            checkOutput($sformatf("tt%0d_diff", i), 16'(d1), 16'(t1[i].diff));
            checkOutput($sformatf("tt%0d_bout", i), 16'(bo1), 16'(t1[i].bout));
            checkOutput($sformatf("tt%0d_valid", i), 16'(ov1), 16'h1);
            checkOutput($sformatf("w8_%0d_diff", i % 6), 16'(d8), 16'(t8[i % 6].diff));
            checkOutput($sformatf("w8_%0d_bout", i % 6), 16'(bo8), 16'(t8[i % 6].bout));
            checkOutput($sformatf("w8_%0d_valid", i % 6), 16'(ov8), 16'h1);
`ifdef FULL_SUBTRACTOR_OVF_EN
            checkOutput($sformatf("w8_%0d_ovf", i % 6), 16'(ovf8), 16'(t8[i % 6].ovf));
`endif
        end

        // Arithmetic model against pseudo-random operands.
        for (int i = 0; i < 20; i++) begin
            ra    = 8'($urandom_range(0, 255));
            rb    = 8'($urandom_range(0, 255));
            rbin  = 1'($urandom_range(0, 1));
            model = {1'b0, ra} - {1'b0, rb} - {8'h00, rbin};
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ra, rb, rbin);
            checkOutput($sformatf("rnd%0d_diff", i), 16'(d8), 16'(model[7:0]));
            checkOutput($sformatf("rnd%0d_bout", i), 16'(bo8), 16'(model[8]));
        end

        // Hold: a valid result followed by three idle cycles with changing inputs.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h22, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1);
            checkOutput($sformatf("hold%0d_valid1", i), 16'(ov1), 16'h0);
            checkOutput($sformatf("hold%0d_diff1", i), 16'(d1), 16'h1);
            checkOutput($sformatf("hold%0d_bout1", i), 16'(bo1), 16'h1);
            checkOutput($sformatf("hold%0d_valid8", i), 16'(ov8), 16'h0);
            checkOutput($sformatf("hold%0d_diff8", i), 16'(d8), 16'h32);
            checkOutput($sformatf("hold%0d_bout8", i), 16'(bo8), 16'h0);
        end

        // Reset in the same cycle as a valid operation discards the operation.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0);
        checkOutput("pre_rst_diff8", 16'(d8), 16'hFF);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0);
        rst = 1'b0;
        checkOutput("rst_op_diff1", 16'(d1), 16'h0);
        checkOutput("rst_op_bout1", 16'(bo1), 16'h0);
        checkOutput("rst_op_valid1", 16'(ov1), 16'h0);
        checkOutput("rst_op_diff8", 16'(d8), 16'h0);
        checkOutput("rst_op_bout8", 16'(bo8), 16'h0);
        checkOutput("rst_op_valid8", 16'(ov8), 16'h0);
`ifdef FULL_SUBTRACTOR_OVF_EN
        checkOutput("rst_op_ovf8", 16'(ovf8), 16'h0);
`endif

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 8'h01, 1'b0);
        checkOutput("post_rst_diff1", 16'(d1), 16'h1);
        checkOutput("post_rst_valid1", 16'(ov1), 16'h1);
        checkOutput("post_rst_diff8", 16'(d8), 16'h02);
        checkOutput("post_rst_bout8", 16'(bo8), 16'h0);
        checkOutput("post_rst_valid8", 16'(ov8), 16'h1);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("idle_valid8", 16'(ov8), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
